// File: rtl/wb_arbiter_n_if.sv
// Bus bundle for the N-master Wishbone arbiter: all per-master request lines,
// the shared slave lines and the grant vector.
interface wb_arbiter_n_if #(
    parameter int unsigned NMASTERS = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
);
    localparam int unsigned SW = DW / 8;

    // Master side
    logic [NMASTERS-1:0]    m_cyc_i;
    logic [NMASTERS-1:0]    m_stb_i;
    logic [NMASTERS-1:0]    m_we_i;
    logic [NMASTERS*AW-1:0] m_adr_i;
    logic [NMASTERS*DW-1:0] m_dat_i;
    logic [NMASTERS*SW-1:0] m_sel_i;
    logic [DW-1:0]          m_dat_o;
    logic [NMASTERS-1:0]    m_ack_o;
    logic [NMASTERS-1:0]    m_err_o;
    logic [NMASTERS-1:0]    gnt_o;

    // Slave side
    logic                   s_cyc_o;
    logic                   s_stb_o;
    logic                   s_we_o;
    logic [AW-1:0]          s_adr_o;
    logic [DW-1:0]          s_dat_o;
    logic [SW-1:0]          s_sel_o;
    logic [DW-1:0]          s_dat_i;
    logic                   s_ack_i;

    // The arbiter serves the masters, so it takes the slave view of this bundle.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    // Surrounding masters and the slave device drive the opposite directions.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );
endinterface

// File: rtl/wb_arbiter_n.sv
// N-master, single-slave Wishbone arbiter. Round-robin or fixed priority, the grant is
// locked for the whole cyc, and a stalled slave is aborted with a one-cycle err pulse.
module wb_arbiter_n #(
    parameter int unsigned NMASTERS = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MODE     = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic           sysclock,
    input logic           rst_i,
    wb_arbiter_n_if.slave bus
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = $clog2(NMASTERS);
    localparam logic [15:0] TO = 16'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [NMASTERS-1:0] err_q, err_d;
    logic [NMASTERS-1:0] gnt_onehot;
    logic                stall;
    logic                expire;

    logic [AW-1:0] adr_arr [NMASTERS];
    logic [DW-1:0] dat_arr [NMASTERS];
    logic [SW-1:0] sel_arr [NMASTERS];

    for (genvar i = 0; i < int'(NMASTERS); i++) begin : g_split
        assign adr_arr[i] = bus.m_adr_i[i*AW +: AW];
        assign dat_arr[i] = bus.m_dat_i[i*DW +: DW];
        assign sel_arr[i] = bus.m_sel_i[i*SW +: SW];
    end

    // Winner among requesters: lowest index (fixed) or first above the pointer (RR).
    function automatic logic [PW-1:0] pick(input logic [NMASTERS-1:0] req,
                                           input logic [PW-1:0]       ptr);
        logic [PW-1:0] win;
        logic          found;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        if (MODE == 1) begin
            for (int i = int'(NMASTERS) - 1; i >= 0; i--) begin
                if (req[i]) win = PW'(i);
            end
        end else begin
            for (int unsigned k = 1; k <= NMASTERS; k++) begin
                idx = (32'(ptr) + k) % NMASTERS;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
        end
        return win;
    endfunction

    assign gnt_onehot  = {{(NMASTERS-1){1'b0}}, 1'b1} << gidx_q;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_err_o = err_q;

    // Next-state, bus muxing and stall timer.
    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = '0;
        err_d       = '0;
        stall       = 1'b0;
        expire      = 1'b0;
        bus.gnt_o   = '0;
        bus.m_ack_o = '0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        unique case (state_q)
            StIdle: begin
                if (|bus.m_cyc_i) begin
                    gidx_d  = pick(bus.m_cyc_i, ptr_q);
                    state_d = StBusy;
                    if (MODE == 0) ptr_d = gidx_d;
                end
            end
            StBusy: begin
                bus.gnt_o   = gnt_onehot;
                bus.s_cyc_o = bus.m_cyc_i[gidx_q];
                bus.s_stb_o = bus.m_stb_i[gidx_q];
                bus.s_we_o  = bus.m_we_i[gidx_q];
                bus.s_adr_o = adr_arr[gidx_q];
                bus.s_dat_o = dat_arr[gidx_q];
                bus.s_sel_o = sel_arr[gidx_q];
                bus.m_ack_o = bus.s_ack_i ? gnt_onehot : '0;
                stall       = bus.m_stb_i[gidx_q] & ~bus.s_ack_i;
                // An ack in the would-be expiry cycle is not a stall, so it wins.
                expire      = (TIMEOUT != 0) && stall && (cnt_q == TO - 16'd1);
                if (stall) cnt_d = cnt_q + 16'd1;
                if (!bus.m_cyc_i[gidx_q]) begin
                    state_d = StIdle;
                end else if (expire) begin
                    state_d = StAbort;
                    err_d   = gnt_onehot;
                end
            end
            StAbort: begin
                // Slave lines stay low and late acks are swallowed until the owner lets go.
                bus.gnt_o = gnt_onehot;
                if (!bus.m_cyc_i[gidx_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset; pointer starts at N-1 so master 0 goes first.
    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            ptr_q   <= PW'(NMASTERS - 1);
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule
